// File: rtl/seq_pkg.sv
// Shared definitions for the stacked-array sequencer: FSM state encoding
// and the width of the ctrl word broadcast to every array.
package seq_pkg;

   localparam int CTRL_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/seq_step_counter.sv
// Loadable up-counter with a terminal-count flag (count == last_i).
// Load wins over enable; the owner stops enabling at terminal count,
// so the counter itself never needs to wrap.
module seq_step_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   input  logic [W-1:0] last_i,
   output logic [W-1:0] count_o,
   output logic         tc_o
);

   logic [W-1:0] count_q, count_d;

   // Next count: load, step, or hold.
   always_comb begin
      // NOTE: assign a default first so every path drives count_d and no latch is inferred.
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign tc_o    = (count_q == last_i);

endmodule

// File: rtl/stacked_array_sequencer.sv
// Job-level controller for the stacked systolic array.
// Per job: accept one input vector, step the weight address 0..ADDR_LAST
// with clock enable, drain the cell pipeline, capture the packed array
// outputs and present them until the consumer takes them.
// Optional feature macro: SEQ_PERF_CNT_EN adds perf_jobs / perf_busy counters.
module stacked_array_sequencer
   import seq_pkg::*;
#(
   parameter int WIDTH                 = 8,
   parameter int ARRAY_COUNT           = 3,
   parameter int CELLS_PER_ARRAY_COUNT = 3,
   parameter int CELL_MEM_ADDR_WIDTH   = 4,
   parameter int ADDR_LAST             = 15
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cfg_we,
   input  logic [CTRL_W-1:0]              cfg_ctrl,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH*ARRAY_COUNT-1:0]   in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WIDTH*ARRAY_COUNT-1:0]   out_data,
   output logic                           busy,
   output logic                           arr_ce,
   output logic [CTRL_W-1:0]              arr_ctrl,
   output logic [CELL_MEM_ADDR_WIDTH-1:0] arr_mem_addr,
   output logic [WIDTH*ARRAY_COUNT-1:0]   arr_x_ins,
   input  logic [WIDTH*ARRAY_COUNT-1:0]   arr_y_out
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0]                    perf_jobs,
   output logic [31:0]                    perf_busy
`endif
);

   localparam int VW = WIDTH * ARRAY_COUNT;
   localparam int AW = CELL_MEM_ADDR_WIDTH;
   localparam int DW = $clog2(CELLS_PER_ARRAY_COUNT + 1);

   localparam logic [AW-1:0] ADDR_LAST_V  = AW'(ADDR_LAST);
   localparam logic [DW-1:0] DRAIN_LAST_V = DW'(CELLS_PER_ARRAY_COUNT - 1);

   seq_state_e state_q, state_d;

   logic [VW-1:0]     x_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic [VW-1:0]     out_data_q;
   logic              out_valid_q;

   // Control strobes from the FSM.
   logic x_we, ctrl_we, capture, out_clr;
   logic addr_load, addr_en, drain_load, drain_en;

   logic [AW-1:0] addr_cnt;
   logic          addr_tc;
   logic [DW-1:0] drain_cnt_unused;
   logic          drain_tc;

   // Weight address: cleared on job accept, stepped through RUN, then held
   // at ADDR_LAST for the drain because RUN stops enabling at terminal count.
   seq_step_counter #(.W(AW)) u_addr_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (addr_load),
      .load_val_i ('0),
      .en_i       (addr_en),
      .last_i     (ADDR_LAST_V),
      .count_o    (addr_cnt),
      .tc_o       (addr_tc)
   );

   // Drain length: CELLS_PER_ARRAY_COUNT cycles, the last one flagged by tc.
   seq_step_counter #(.W(DW)) u_drain_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (drain_load),
      .load_val_i ('0),
      .en_i       (drain_en),
      .last_i     (DRAIN_LAST_V),
      .count_o    (drain_cnt_unused),
      .tc_o       (drain_tc)
   );

   // FSM next-state and strobe decode.
   always_comb begin
      state_d    = state_q;
      x_we       = 1'b0;
      ctrl_we    = 1'b0;
      capture    = 1'b0;
      out_clr    = 1'b0;
      addr_load  = 1'b0;
      addr_en    = 1'b0;
      drain_load = 1'b0;
      drain_en   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // ctrl writes land only here, so the word is frozen for the whole job.
            ctrl_we = cfg_we;
            if (in_valid) begin
               x_we      = 1'b1;
               addr_load = 1'b1;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (addr_tc) begin
               drain_load = 1'b1;
               state_d    = ST_DRAIN;
            end else begin
               addr_en = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drain_tc) begin
               capture = 1'b1;
               state_d = ST_HOLD;
            end else begin
               drain_en = 1'b1;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               out_clr = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Job data registers: held input vector, ctrl word, captured result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q         <= '0;
         ctrl_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (x_we)    x_q    <= in_data;
         if (ctrl_we) ctrl_q <= cfg_ctrl;
         if (capture) begin
            out_data_q  <= arr_y_out;
            out_valid_q <= 1'b1;
         end else if (out_clr) begin
            out_valid_q <= 1'b0;
         end
      end
   end

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] perf_jobs_q, perf_busy_q;

   // Performance counters: completed out handshakes and busy cycles; both wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_jobs_q <= '0;
         perf_busy_q <= '0;
      end else begin
         if (out_valid_q && out_ready) perf_jobs_q <= perf_jobs_q + 32'd1;
         if (state_q != ST_IDLE)       perf_busy_q <= perf_busy_q + 32'd1;
      end
   end

   assign perf_jobs = perf_jobs_q;
   assign perf_busy = perf_busy_q;
`endif

   assign in_ready     = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);
   assign arr_ce       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign arr_mem_addr = addr_cnt;
   assign arr_x_ins    = x_q;
   assign arr_ctrl     = ctrl_q;
   assign out_data     = out_data_q;
   assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_stacked_array_sequencer.sv
// Self-checking bench for stacked_array_sequencer. The reference model
// derives expected address/enable/result timing directly from the job
// phase lengths (ADDR_LAST+1 run cycles, CELLS drain cycles) and tracks
// the ctrl register value the IDLE-only write rule implies.
module tb_stacked_array_sequencer;

   localparam int WIDTH     = 8;
   localparam int AC        = 3;
   localparam int CELLS     = 3;
   localparam int AW        = 4;
   localparam int ADDR_LAST = 15;
   localparam int VW        = WIDTH * AC;
   localparam int JOB_LEN   = ADDR_LAST + 1 + CELLS;   // busy cycles before HOLD

   logic          clk, rst_n;
   logic          cfg_we;
   logic [31:0]   cfg_ctrl;
   logic          in_valid, in_ready;
   logic [VW-1:0] in_data;
   logic          out_valid, out_ready;
   logic [VW-1:0] out_data;
   logic          busy, arr_ce;
   logic [31:0]   arr_ctrl;
   logic [AW-1:0] arr_mem_addr;
   logic [VW-1:0] arr_x_ins, arr_y_out;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0]   perf_jobs, perf_busy;
`endif

   stacked_array_sequencer #(
      .WIDTH                 (WIDTH),
      .ARRAY_COUNT           (AC),
      .CELLS_PER_ARRAY_COUNT (CELLS),
      .CELL_MEM_ADDR_WIDTH   (AW),
      .ADDR_LAST             (ADDR_LAST)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_we       (cfg_we),
      .cfg_ctrl     (cfg_ctrl),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .busy         (busy),
      .arr_ce       (arr_ce),
      .arr_ctrl     (arr_ctrl),
      .arr_mem_addr (arr_mem_addr),
      .arr_x_ins    (arr_x_ins),
      .arr_y_out    (arr_y_out)
`ifdef SEQ_PERF_CNT_EN
      ,
      .perf_jobs    (perf_jobs),
      .perf_busy    (perf_busy)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_ctrl;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Apply reset across two edges and check the reset state (state IDLE).
   task automatic do_reset();
      rst_n = 1'b0; cfg_we = 1'b0; cfg_ctrl = '0; in_valid = 1'b0;
      in_data = '0; out_ready = 1'b0; arr_y_out = '0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_arr_ce", arr_ce, 0);
      check("rst_busy", busy, 0);
      check("rst_addr", arr_mem_addr, 0);
      check("rst_ctrl", arr_ctrl, 0);
      check("rst_x", arr_x_ins, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      exp_ctrl = '0;
      @(negedge clk);
   endtask

   // One job starting from an IDLE negedge. cycle n = n-th cycle after the
   // input handshake edge. abort_addr >= 0 pulses reset when the model
   // expects that address in RUN.
   task automatic run_job(input logic [VW-1:0] vec, input bit cfg_hs, input logic [31:0] cfg_val,
                          input bit cfg_mid, input int hold_cycles, input int abort_addr);
      logic [VW-1:0] captured;
      logic [AW-1:0] exp_addr;
      captured = '0;
      in_valid = 1'b1; in_data = vec; cfg_we = cfg_hs; cfg_ctrl = cfg_val;
      check("in_ready_idle", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0; in_data = VW'($urandom); cfg_we = 1'b0;
      if (cfg_hs) exp_ctrl = cfg_val;
      for (int n = 1; n <= JOB_LEN; n++) begin
         exp_addr = (n <= ADDR_LAST + 1) ? AW'(n - 1) : AW'(ADDR_LAST);
         if (abort_addr >= 0 && n == abort_addr + 1) begin
            check("pre_abort_addr", arr_mem_addr, exp_addr);
            #1 rst_n = 1'b0;
            #1;
            check("abort_out_valid", out_valid, 0);
            check("abort_arr_ce", arr_ce, 0);
            check("abort_busy", busy, 0);
            check("abort_addr", arr_mem_addr, 0);
            check("abort_ctrl", arr_ctrl, 0);
            check("abort_x", arr_x_ins, 0);
            check("abort_out_data", out_data, 0);
            exp_ctrl = '0;
            #1 rst_n = 1'b1;
            out_ready = 1'b1;
            for (int k = 0; k < JOB_LEN + 6; k++) begin
               @(negedge clk);
               check("post_abort_no_valid", out_valid, 0);
               check("post_abort_idle", busy, 0);
            end
            out_ready = 1'b0;
            return;
         end
         check("run_addr", arr_mem_addr, exp_addr);
         check("run_ce", arr_ce, 1);
         check("run_busy", busy, 1);
         check("run_in_ready", in_ready, 0);
         check("run_out_valid", out_valid, 0);
         check("run_ctrl", arr_ctrl, exp_ctrl);
         check("run_x", arr_x_ins, vec);
         arr_y_out = VW'($urandom);
         if (n == JOB_LEN) captured = arr_y_out;   // sampled on the last drain edge
         if (cfg_mid && n == 5) begin
            cfg_we = 1'b1; cfg_ctrl = 32'hA5A5_0001;
         end else begin
            cfg_we = 1'b0;
         end
         @(negedge clk);
      end
      cfg_we = 1'b0;
      for (int h = 0; h <= hold_cycles; h++) begin
         check("hold_out_valid", out_valid, 1);
         check("hold_out_data", out_data, captured);
         check("hold_ce", arr_ce, 0);
         check("hold_in_ready", in_ready, 0);
         check("hold_ctrl", arr_ctrl, exp_ctrl);
         check("hold_x", arr_x_ins, vec);
         arr_y_out = VW'($urandom);
         out_ready = (h == hold_cycles);
         @(negedge clk);
      end
      out_ready = 1'b0;
      check("post_out_valid", out_valid, 0);
      check("post_in_ready", in_ready, 1);
      check("post_busy", busy, 0);
   endtask

   initial begin
      logic [31:0] r;
      do_reset();

      // Basic job with a long HOLD.
      run_job(24'h030201, 1'b0, 32'h0, 1'b0, 10, -1);

      // ctrl write during RUN is ignored.
      run_job(VW'($urandom), 1'b0, 32'h0, 1'b1, 0, -1);

      // ctrl write in IDLE lands next cycle.
      cfg_we = 1'b1; cfg_ctrl = 32'hA5A5_0001;
      @(negedge clk);
      cfg_we = 1'b0;
      exp_ctrl = 32'hA5A5_0001;
      check("idle_cfg_write", arr_ctrl, exp_ctrl);

      // ctrl write together with input handshake.
      run_job(VW'($urandom), 1'b1, 32'h0000_0002, 1'b0, 2, -1);

      // Reset mid-RUN at address 7, then a clean job from address 0.
      run_job(VW'($urandom), 1'b0, 32'h0, 1'b0, 0, 7);
      run_job(VW'($urandom), 1'b0, 32'h0, 1'b0, 1, -1);

      // Randomized jobs with idle gaps and IDLE ctrl writes.
      for (int j = 0; j < 6; j++) begin
         r = $urandom;
         if (r[0]) begin
            cfg_we = 1'b1; cfg_ctrl = $urandom;
            @(negedge clk);
            cfg_we = 1'b0;
            exp_ctrl = cfg_ctrl;
            check("rand_idle_cfg", arr_ctrl, exp_ctrl);
         end
         repeat (int'(r[3:2])) begin
            @(negedge clk);
            check("rand_idle_ready", in_ready, 1);
         end
         run_job(VW'($urandom), r[4], $urandom, r[5], int'($urandom_range(0, 4)), -1);
      end

`ifdef SEQ_PERF_CNT_EN
      do_reset();
      check("perf_jobs_rst", perf_jobs, 0);
      check("perf_busy_rst", perf_busy, 0);
      for (int j = 0; j < 3; j++) run_job(VW'($urandom), 1'b0, 32'h0, 1'b0, 0, -1);
      check("perf_jobs", perf_jobs, 3);
      check("perf_busy", perf_busy, 3 * (JOB_LEN + 1));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
